// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selection: round-robin on a last-grant pointer, or fixed priority
// to the CPU port. The pointer only moves when the caller commits the grant.
module rr_arbiter2
    import dmem_arb_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_valid,
    output logic       grant
);

    logic last;

    always_comb begin
        grant_valid = |req;
        grant       = PORT_CPU;
        if (req[0] && req[1]) begin
            grant = (ARB_MODE == 1) ? PORT_CPU : ~last;
        end else if (req[1]) begin
            grant = PORT_DBG;
        end
    end

    // Reset value points at the debug port so the CPU wins the first contested grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= PORT_DBG;
        end else if (update && grant_valid) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU and a debug/DMA port; each
// granted request becomes a one-cycle memory access followed by a one-cycle ack.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [DATA_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [DATA_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

    state_t            state;
    logic              lat_port;
    logic              lat_we;
    logic              lat_err;

    logic              grant_valid;
    logic              grant;
    logic              sel_we;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    rr_arbiter2 #(
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         ({p1_req, p0_req}),
        .update      (state == IDLE),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        sel_we       = (grant == PORT_DBG) ? p1_we    : p0_we;
        sel_addr     = (grant == PORT_DBG) ? p1_addr  : p0_addr;
        sel_wdata    = (grant == PORT_DBG) ? p1_wdata : p0_wdata;
        sel_in_range = (sel_addr < DEPTH_W);
    end

    assign busy = (state != IDLE);

    // mem_addr/mem_wdata double as the request latch: loaded once on grant and held
    // through ACCESS, so the level-sensitive memory write sees stable inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_port  <= PORT_CPU;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            p0_ack    <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_ack    <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            // NOTE: non-blocking defaults make ack/err single-cycle pulses; the DONE
            // entry below overrides them for exactly one cycle.
            p0_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_ack <= 1'b0;
            p1_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_port  <= grant;
                        lat_we    <= sel_we;
                        lat_err   <= ~sel_in_range;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_write <= sel_we & sel_in_range;
                        mem_read  <= ~sel_we & sel_in_range;
                        state     <= ACCESS;
                    end
                end

                ACCESS: begin
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    if (!lat_we && !lat_err) begin
                        if (lat_port == PORT_DBG) p1_rdata <= mem_rdata;
                        else                      p0_rdata <= mem_rdata;
                    end
                    if (lat_port == PORT_DBG) begin
                        p1_ack <= 1'b1;
                        p1_err <= lat_err;
                    end else begin
                        p0_ack <= 1'b1;
                        p0_err <= lat_err;
                    end
                    state <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_single_write: assert property (@(posedge clk) disable iff (!reset_n)
        mem_write |=> !mem_write);

    a_ack_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(p0_ack && p1_ack));

    a_no_read_write: assert property (@(posedge clk) disable iff (!reset_n)
        !(mem_read && mem_write));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model with a per-cycle
// compare, directed scenarios with literal expectations, and a fixed-priority instance.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read, busy;

    logic        fp_p0_req = 1'b0, fp_p1_req = 1'b0;
    logic [31:0] fp_p0_addr = '0, fp_p1_addr = '0;
    logic        fp_p0_ack, fp_p0_err, fp_p1_ack, fp_p1_err;
    logic [31:0] fp_p0_rdata, fp_p1_rdata;
    logic [31:0] fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
    logic        fp_mem_write, fp_mem_read, fp_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(256), .ARB_MODE(0)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.DEPTH(256), .ARB_MODE(1)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .p0_req(fp_p0_req), .p0_we(1'b0), .p0_addr(fp_p0_addr), .p0_wdata(32'h0),
        .p0_ack(fp_p0_ack), .p0_rdata(fp_p0_rdata), .p0_err(fp_p0_err),
        .p1_req(fp_p1_req), .p1_we(1'b0), .p1_addr(fp_p1_addr), .p1_wdata(32'h0),
        .p1_ack(fp_p1_ack), .p1_rdata(fp_p1_rdata), .p1_err(fp_p1_err),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_write(fp_mem_write),
        .mem_read(fp_mem_read), .mem_rdata(fp_mem_rdata), .busy(fp_busy)
    );

    // Environment memories: a real RAM for the main instance, an address pattern for the other.
    logic [31:0] dmem [256];
    int          wr_count = 0;
    assign mem_rdata    = (mem_addr < 32'd256) ? dmem[mem_addr[7:0]] : 32'hBAD0_BAD0;
    assign fp_mem_rdata = fp_mem_addr ^ 32'h5A5A_0000;

    always @(posedge clk) begin
        if (mem_write) begin
            wr_count++;
            if (mem_addr < 32'd256) dmem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 memory access, 2 acknowledge.
    int          m_phase = 0;
    logic        m_last  = 1'b1;
    logic        m_port = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
    logic [31:0] ref_mem [256];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase    = 0;
            m_last     = 1'b1;
            m_rdata[0] = '0;
            m_rdata[1] = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (p0_req || p1_req) begin
                        m_port  = (p0_req && p1_req) ? ~m_last : p1_req;
                        m_last  = m_port;
                        m_we    = m_port ? p1_we    : p0_we;
                        m_addr  = m_port ? p1_addr  : p0_addr;
                        m_wdata = m_port ? p1_wdata : p0_wdata;
                        m_err   = (m_addr >= 32'd256);
                        m_phase = 1;
                    end
                end
                1: begin
                    if (!m_err) begin
                        if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
                        else      m_rdata[m_port] = ref_mem[m_addr[7:0]];
                    end
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("busy",      busy,      m_phase != 0);
        check("mem_write", mem_write, m_phase == 1 && m_we && !m_err);
        check("mem_read",  mem_read,  m_phase == 1 && !m_we && !m_err);
        check("p0_ack",    p0_ack,    m_phase == 2 && m_port == 1'b0);
        check("p1_ack",    p1_ack,    m_phase == 2 && m_port == 1'b1);
        check("p0_err",    p0_err,    m_phase == 2 && m_port == 1'b0 && m_err);
        check("p1_err",    p1_err,    m_phase == 2 && m_port == 1'b1 && m_err);
        check("p0_rdata",  p0_rdata,  m_rdata[0]);
        check("p1_rdata",  p1_rdata,  m_rdata[1]);
        if (m_phase == 1) begin
            check("mem_addr",  mem_addr,  m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
        end
    end

    task automatic do_op(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] rdata,
                         output logic err, output int lat);
        logic done;
        @(posedge clk); #1;
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = data;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = data;
        end
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (port ? p1_ack : p0_ack) done = 1'b1;
        end
        check("op_ack_seen", done, 1'b1);
        rdata = port ? p1_rdata : p0_rdata;
        err   = port ? p1_err   : p0_err;
        @(posedge clk); #1;
        if (port) p1_req = 1'b0;
        else      p0_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, wc0, cnt, n0, n1;
        logic        seen;
        logic        grants [$];

        for (int i = 0; i < 256; i++) begin
            dmem[i]    = '0;
            ref_mem[i] = '0;
        end

        // Reset: all outputs cleared, then quiet idle cycles after release.
        repeat (2) @(negedge clk);
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_busy",      busy,      1'b0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // CPU write then read-back of address 5.
        wc0 = wr_count;
        do_op(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, rd, er, lat);
        check("wr5_err", er, 1'b0);
        check("wr5_rdata_unchanged", rd, 32'h0);
        check("wr5_latency", lat, 3);
        check("wr5_single_write", wr_count - wc0, 1);
        do_op(1'b0, 1'b0, 32'd5, 32'h0, rd, er, lat);
        check("rd5_rdata", rd, 32'hDEAD_BEEF);
        check("rd5_err", er, 1'b0);
        check("rd5_latency", lat, 3);

        // CPU drops its request right after acceptance; the write still completes once.
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd20; p0_wdata = 32'h0BAD_F00D;
        @(posedge clk); #1 p0_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (p0_ack) cnt++;
        end
        check("drop_ack_once", cnt, 1);
        do_op(1'b0, 1'b0, 32'd20, 32'h0, rd, er, lat);
        check("drop_readback", rd, 32'h0BAD_F00D);

        // Debug port: valid read, then out-of-range read keeps previous rdata.
        do_op(1'b1, 1'b1, 32'd9, 32'hCAFE_0009, rd, er, lat);
        do_op(1'b1, 1'b0, 32'd9, 32'h0, rd, er, lat);
        check("rd9_rdata", rd, 32'hCAFE_0009);
        wc0 = wr_count;
        do_op(1'b1, 1'b0, 32'd256, 32'h0, rd, er, lat);
        check("oor_err", er, 1'b1);
        check("oor_rdata_held", rd, 32'hCAFE_0009);
        check("oor_no_write", wr_count - wc0, 0);

        // Reset in the middle of a debug write: no ack, idle, then reissue succeeds.
        @(posedge clk); #1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd7; p1_wdata = 32'h1234_5678;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (mem_write) seen = 1'b1;
        end
        check("abort_access_reached", seen, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy",      busy,      1'b0);
        check("abort_p1_ack",    p1_ack,    1'b0);
        check("abort_mem_write", mem_write, 1'b0);
        check("abort_mem_addr",  mem_addr,  32'h0);
        check("abort_p1_rdata",  p1_rdata,  32'h0);
        @(posedge clk); #1;
        p1_req  = 1'b0;
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (p1_ack) cnt++;
        end
        check("abort_no_ack", cnt, 0);
        do_op(1'b1, 1'b1, 32'd7, 32'h1234_5678, rd, er, lat);
        check("reissue_err", er, 1'b0);
        check("reissue_latency", lat, 3);
        do_op(1'b1, 1'b0, 32'd7, 32'h0, rd, er, lat);
        check("reissue_readback", rd, 32'h1234_5678);

        // Both ports held for four transactions: round-robin alternates starting with CPU.
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd5;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd7;
        for (int i = 0; i < 20 && grants.size() < 4; i++) begin
            @(negedge clk);
            if (p0_ack) grants.push_back(1'b0);
            if (p1_ack) grants.push_back(1'b1);
        end
        @(posedge clk); #1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        check("rr_count", grants.size(), 4);
        if (grants.size() == 4) begin
            check("rr_grant0", grants[0], 1'b0);
            check("rr_grant1", grants[1], 1'b1);
            check("rr_grant2", grants[2], 1'b0);
            check("rr_grant3", grants[3], 1'b1);
        end
        check("rr_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
        check("rr_p1_rdata", p1_rdata, 32'h1234_5678);

        // Fixed priority: CPU monopolises while held, debug port served once it drops.
        @(posedge clk); #1;
        fp_p0_req = 1'b1; fp_p0_addr = 32'd1;
        fp_p1_req = 1'b1; fp_p1_addr = 32'd2;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 20 && n0 < 3; i++) begin
            @(negedge clk);
            if (fp_p0_ack) n0++;
            if (fp_p1_ack) n1++;
            if (fp_mem_write) n1 += 100;
        end
        @(posedge clk); #1 fp_p0_req = 1'b0;
        check("fp_p0_grants", n0, 3);
        check("fp_p1_starved", n1, 0);
        check("fp_p0_rdata", fp_p0_rdata, 32'h5A5A_0001);
        check("fp_p0_err", fp_p0_err, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (fp_p1_ack) begin
                seen = 1'b1;
                check("fp_p1_rdata", fp_p1_rdata, 32'h5A5A_0002);
                check("fp_p1_err", fp_p1_err, 1'b0);
            end
        end
        check("fp_p1_served", seen, 1'b1);
        @(posedge clk); #1 fp_p1_req = 1'b0;
        repeat (2) @(negedge clk);
        check("fp_idle", {fp_busy, fp_mem_read}, 2'b00);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
